// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM state,
// bus/writeback payload structs and small op-decoding helpers.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 4;
  localparam int unsigned BE_W = 4;
  localparam int unsigned RD_W = 5;

  localparam logic [OP_W-1:0] OP_NONE = 4'b0000;
  localparam logic [OP_W-1:0] OP_LB   = 4'b0001;
  localparam logic [OP_W-1:0] OP_LH   = 4'b0010;
  localparam logic [OP_W-1:0] OP_LW   = 4'b0011;
  localparam logic [OP_W-1:0] OP_LBU  = 4'b0100;
  localparam logic [OP_W-1:0] OP_LHU  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SB   = 4'b1000;
  localparam logic [OP_W-1:0] OP_SH   = 4'b1001;
  localparam logic [OP_W-1:0] OP_SW   = 4'b1010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Registered data-memory command, held stable until the ack cycle.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dmem_cmd_t;

  // Writeback record payload (valid travels separately as a pulse).
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            reg_write;
  } wb_rec_t;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_byte_op(input logic [OP_W-1:0] op);
    return op inside {OP_LB, OP_LBU, OP_SB};
  endfunction

  function automatic logic is_half_op(input logic [OP_W-1:0] op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic is_word_op(input logic [OP_W-1:0] op);
    return op inside {OP_LW, OP_SW};
  endfunction

  function automatic logic is_misaligned(input logic [OP_W-1:0] op,
                                         input logic [1:0]      lo);
    return (is_half_op(op) && lo[0]) || (is_word_op(op) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory (slave).
//   req/we/addr/be/wdata : command, driven by the master
//   ack/rdata            : completion and read data, driven by the slave
interface mem_stage_lsu_if;
  import lsu_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] wdata;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: byte enables and lane-replicated store data for the
// outgoing request, plus lane selection and sign/zero extension of load data.
//   op, addr_lo          : memory op and low address bits
//   store_data, rdata    : raw store operand and raw bus read data
//   be, wdata, load_data : lane enables, replicated store data, extended load
module lsu_align
  import lsu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane enables by access size.
  always_comb begin
    be = '0;
    if (is_byte_op(op))      be = BE_W'(4'b0001 << addr_lo);
    else if (is_half_op(op)) be = addr_lo[1] ? 4'b1100 : 4'b0011;
    else if (is_word_op(op)) be = 4'b1111;
  end

  // Replicate narrow store data so the selected lanes carry it regardless of offset.
  always_comb begin
    wdata = store_data;
    if (op == OP_SB)      wdata = {4{store_data[7:0]}};
    else if (op == OP_SH) wdata = {2{store_data[15:0]}};
  end

  // Lane selection and extension of read data.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Accepts one instruction from EX, either passes the
// ALU result straight to writeback or runs a data-memory transaction, and
// stalls EX while that transaction is outstanding.
//   clk, rstn              : clock, async active-low reset
//   ex_*                   : EX-stage instruction handshake and payload
//   flush                  : kill the current or incoming instruction
//   dmem                   : data-memory bus (master side)
//   wb_*                   : one-cycle writeback record
//   misalign, bus_err      : single-cycle fault pulses, fault_addr holds the byte address
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
)
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       ex_alu_c,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [OP_W-1:0]       ex_mem_op,
  input  logic [RD_W-1:0]       ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  flush,
  mem_stage_lsu_if.master       dmem,
  output logic                  wb_valid,
  output logic [RD_W-1:0]       wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_reg_write,
  output logic                  misalign,
  output logic                  bus_err,
  output logic [XLEN-1:0]       fault_addr
);

  state_t          state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic            killed_q, killed_n;
  logic [OP_W-1:0] op_q, op_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic [RD_W-1:0] rd_q, rd_n;
  logic            rw_q, rw_n;
  logic            req_q, req_n;
  dmem_cmd_t       cmd_q, cmd_n;
  logic            wb_valid_q, wb_valid_n;
  wb_rec_t         wb_q, wb_n;
  logic            misalign_q, misalign_n;
  logic            bus_err_q, bus_err_n;
  logic [XLEN-1:0] fault_q, fault_n;

  logic            accept;
  logic            mem_op;
  logic            timeout;
  logic [CNT_W-1:0] cnt_inc;
  logic [OP_W-1:0] align_op;
  logic [1:0]      align_lo;
  logic [BE_W-1:0] align_be;
  logic [XLEN-1:0] align_wdata;
  logic [XLEN-1:0] align_load;

  assign ex_ready = rstn && (state_q == ST_IDLE) && !flush;
  assign accept   = ex_valid && ex_ready;
  assign mem_op   = is_load(ex_mem_op) || is_store(ex_mem_op);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign timeout  = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));

  // One aligner serves both the accept path (EX inputs) and the ack path (held op).
  assign align_op = (state_q == ST_BUSY) ? op_q : ex_mem_op;
  assign align_lo = (state_q == ST_BUSY) ? addr_q[1:0] : ex_alu_c[1:0];

  lsu_align u_align (
    .op         (align_op),
    .addr_lo    (align_lo),
    .store_data (ex_store_data),
    .rdata      (dmem.rdata),
    .be         (align_be),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    killed_n   = killed_q;
    op_n       = op_q;
    addr_n     = addr_q;
    rd_n       = rd_q;
    rw_n       = rw_q;
    req_n      = req_q;
    cmd_n      = cmd_q;
    wb_valid_n = 1'b0;
    wb_n       = wb_q;
    misalign_n = 1'b0;
    bus_err_n  = 1'b0;
    fault_n    = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!mem_op) begin
            wb_valid_n = 1'b1;
            wb_n       = '{rd: ex_rd, data: ex_alu_c,
                           reg_write: ex_reg_write && (ex_rd != '0)};
          end else if (is_misaligned(ex_mem_op, ex_alu_c[1:0])) begin
            misalign_n = 1'b1;
            fault_n    = ex_alu_c;
          end else begin
            req_n    = 1'b1;
            cmd_n    = '{we: is_store(ex_mem_op), addr: {ex_alu_c[31:2], 2'b00},
                         be: align_be, wdata: align_wdata};
            op_n     = ex_mem_op;
            addr_n   = ex_alu_c;
            rd_n     = ex_rd;
            rw_n     = ex_reg_write;
            killed_n = 1'b0;
            cnt_n    = '0;
            state_n  = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        // A flush cannot abort the bus cycle; remember it to drop the writeback.
        killed_n = killed_q || flush;
        if (dmem.ack) begin
          req_n   = 1'b0;
          state_n = ST_IDLE;
          cnt_n   = '0;
          if (!(killed_q || flush)) begin
            wb_valid_n = 1'b1;
            if (is_load(op_q)) begin
              wb_n = '{rd: rd_q, data: align_load, reg_write: rw_q && (rd_q != '0)};
            end else begin
              wb_n = '{rd: rd_q, data: '0, reg_write: 1'b0};
            end
          end
        end else if (timeout) begin
          req_n     = 1'b0;
          state_n   = ST_IDLE;
          cnt_n     = '0;
          bus_err_n = 1'b1;
          fault_n   = addr_q;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      killed_q   <= 1'b0;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      req_q      <= 1'b0;
      cmd_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      fault_q    <= '0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      killed_q   <= killed_n;
      op_q       <= op_n;
      addr_q     <= addr_n;
      rd_q       <= rd_n;
      rw_q       <= rw_n;
      req_q      <= req_n;
      cmd_q      <= cmd_n;
      wb_valid_q <= wb_valid_n;
      wb_q       <= wb_n;
      misalign_q <= misalign_n;
      bus_err_q  <= bus_err_n;
      fault_q    <= fault_n;
    end
  end

  assign dmem.req     = req_q;
  assign dmem.we      = cmd_q.we;
  assign dmem.addr    = cmd_q.addr;
  assign dmem.be      = cmd_q.be;
  assign dmem.wdata   = cmd_q.wdata;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_q.rd;
  assign wb_data      = wb_q.data;
  assign wb_reg_write = wb_q.reg_write;
  assign misalign     = misalign_q;
  assign bus_err      = bus_err_q;
  assign fault_addr   = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu. A second instance with a short watchdog
// shares the EX inputs but never sees an ack; it is only checked in the
// timeout step.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid;
  logic [31:0] ex_alu_c;
  logic [31:0] ex_store_data;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        flush;

  logic        ex_ready, wb_valid, wb_reg_write, misalign, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr;

  logic        wd_ex_ready, wd_wb_valid, wd_wb_reg_write, wd_misalign, wd_bus_err;
  logic [4:0]  wd_wb_rd;
  logic [31:0] wd_wb_data, wd_fault_addr;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu_if bus ();
  mem_stage_lsu_if bus_wd ();

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_c(ex_alu_c),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .flush(flush), .dmem(bus.master),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .misalign(misalign), .bus_err(bus_err),
    .fault_addr(fault_addr)
  );

  mem_stage_lsu #(.TIMEOUT_CYC(4), .CNT_W(8)) dut_wd (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_ready(wd_ex_ready), .ex_alu_c(ex_alu_c),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .flush(flush), .dmem(bus_wd.master),
    .wb_valid(wd_wb_valid), .wb_rd(wd_wb_rd), .wb_data(wd_wb_data),
    .wb_reg_write(wd_wb_reg_write), .misalign(wd_misalign), .bus_err(wd_bus_err),
    .fault_addr(wd_fault_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rd, input logic rw);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_alu_c      = alu;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_reg_write  = rw;
    #1;
  endtask

  task automatic idle_in();
    ex_valid      = 1'b0;
    ex_mem_op     = OP_NONE;
    ex_alu_c      = '0;
    ex_store_data = '0;
    ex_rd         = '0;
    ex_reg_write  = 1'b0;
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    bus.ack = 1'b0;
    bus.rdata = '0;
    bus_wd.ack = 1'b0;
    bus_wd.rdata = '0;
    idle_in();

    // Reset state
    tick();
    chk("rst_ex_ready", 32'(ex_ready), 32'd0);
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    rstn = 1'b1;
    tick();
    chk("idle_ex_ready", 32'(ex_ready), 32'd1);

    // NONE op pass-through
    present(OP_NONE, 32'h12345678, 32'h0, 5'd5, 1'b1);
    tick();
    chk("none_wb_valid", 32'(wb_valid), 32'd1);
    chk("none_wb_data", wb_data, 32'h12345678);
    chk("none_wb_rd", 32'(wb_rd), 32'd5);
    chk("none_wb_rw", 32'(wb_reg_write), 32'd1);
    chk("none_req", 32'(bus.req), 32'd0);

    // Back-to-back NONE / illegal ops, one writeback per cycle
    present(OP_NONE, 32'h00000100, 32'h0, 5'd1, 1'b1);
    tick();
    chk("b2b0_valid", 32'(wb_valid), 32'd1);
    chk("b2b0_data", wb_data, 32'h00000100);
    present(4'b1111, 32'h00000101, 32'h0, 5'd2, 1'b1);
    tick();
    chk("b2b1_valid", 32'(wb_valid), 32'd1);
    chk("b2b1_data", wb_data, 32'h00000101);
    present(OP_NONE, 32'h00000102, 32'h0, 5'd0, 1'b1);
    tick();
    chk("b2b2_valid", 32'(wb_valid), 32'd1);
    chk("b2b2_rw_rd0", 32'(wb_reg_write), 32'd0);
    present(4'b0110, 32'h00000103, 32'h0, 5'd4, 1'b0);
    tick();
    chk("b2b3_valid", 32'(wb_valid), 32'd1);
    chk("b2b3_data", wb_data, 32'h00000103);
    chk("b2b3_rw", 32'(wb_reg_write), 32'd0);
    chk("b2b_req", 32'(bus.req), 32'd0);
    idle_in();
    tick();
    chk("b2b_end_valid", 32'(wb_valid), 32'd0);

    // LB at 0x1003, ack two cycles after req
    present(OP_LB, 32'h00001003, 32'h0, 5'd7, 1'b1);
    tick();
    idle_in();
    chk("lb_req", 32'(bus.req), 32'd1);
    chk("lb_addr", bus.addr, 32'h00001000);
    chk("lb_be", 32'(bus.be), 32'h8);
    chk("lb_we", 32'(bus.we), 32'd0);
    chk("lb_busy_ready", 32'(ex_ready), 32'd0);
    tick();
    chk("lb_req_hold", 32'(bus.req), 32'd1);
    tick();
    bus.ack = 1'b1;
    bus.rdata = 32'h80FF0000;
    chk("lb_req_ackcyc", 32'(bus.req), 32'd1);
    tick();
    bus.ack = 1'b0;
    chk("lb_req_drop", 32'(bus.req), 32'd0);
    chk("lb_wb_valid", 32'(wb_valid), 32'd1);
    chk("lb_wb_data", wb_data, 32'hFFFFFF80);
    chk("lb_wb_rd", 32'(wb_rd), 32'd7);
    chk("lb_wb_rw", 32'(wb_reg_write), 32'd1);
    chk("lb_ready_with_wb", 32'(ex_ready), 32'd1);

    // Same access as LBU
    present(OP_LBU, 32'h00001003, 32'h0, 5'd7, 1'b1);
    tick();
    idle_in();
    chk("lbu_be", 32'(bus.be), 32'h8);
    tick();
    tick();
    bus.ack = 1'b1;
    bus.rdata = 32'h80FF0000;
    tick();
    bus.ack = 1'b0;
    chk("lbu_wb_valid", 32'(wb_valid), 32'd1);
    chk("lbu_wb_data", wb_data, 32'h00000080);

    // LH at 0x1002 sign-extends the upper half
    present(OP_LH, 32'h00001002, 32'h0, 5'd8, 1'b1);
    tick();
    idle_in();
    chk("lh_be", 32'(bus.be), 32'hC);
    bus.ack = 1'b1;
    bus.rdata = 32'h9ABC0000;
    tick();
    bus.ack = 1'b0;
    chk("lh_wb_data", wb_data, 32'hFFFF9ABC);

    // SH at 0x2002, ack in the first req cycle
    present(OP_SH, 32'h00002002, 32'hABCD1234, 5'd9, 1'b1);
    tick();
    idle_in();
    chk("sh_req", 32'(bus.req), 32'd1);
    chk("sh_we", 32'(bus.we), 32'd1);
    chk("sh_be", 32'(bus.be), 32'hC);
    chk("sh_wdata", bus.wdata, 32'h12341234);
    chk("sh_addr", bus.addr, 32'h00002000);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);
    chk("sh_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("sh_wb_data", wb_data, 32'h0);

    // SB at 0x2001 replicates the byte, single lane enabled
    present(OP_SB, 32'h00002001, 32'h000000A5, 5'd3, 1'b1);
    tick();
    idle_in();
    chk("sb_be", 32'(bus.be), 32'h2);
    chk("sb_wdata", bus.wdata, 32'hA5A5A5A5);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("sb_wb_valid", 32'(wb_valid), 32'd1);

    // Misaligned LW
    present(OP_LW, 32'h00003001, 32'h0, 5'd6, 1'b1);
    tick();
    idle_in();
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_fault_addr", fault_addr, 32'h00003001);
    chk("mis_wb_valid", 32'(wb_valid), 32'd0);
    chk("mis_req", 32'(bus.req), 32'd0);
    chk("mis_ready", 32'(ex_ready), 32'd1);
    tick();
    chk("mis_pulse_end", 32'(misalign), 32'd0);
    chk("mis_req_after", 32'(bus.req), 32'd0);

    // Misaligned SH at odd address
    present(OP_SH, 32'h00003003, 32'h0, 5'd6, 1'b0);
    tick();
    idle_in();
    chk("mis_sh_pulse", 32'(misalign), 32'd1);
    chk("mis_sh_req", 32'(bus.req), 32'd0);

    // LW to rd 0: writeback valid without register write
    present(OP_LW, 32'h00003000, 32'h0, 5'd0, 1'b1);
    tick();
    idle_in();
    chk("lw0_be", 32'(bus.be), 32'hF);
    bus.ack = 1'b1;
    bus.rdata = 32'hDEADBEEF;
    tick();
    bus.ack = 1'b0;
    chk("lw0_wb_valid", 32'(wb_valid), 32'd1);
    chk("lw0_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("lw0_wb_data", wb_data, 32'hDEADBEEF);

    // Flush during BUSY: bus runs to ack, writeback suppressed
    present(OP_LW, 32'h00004000, 32'h0, 5'd3, 1'b1);
    tick();
    idle_in();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req_hold1", 32'(bus.req), 32'd1);
    tick();
    chk("fl_req_hold2", 32'(bus.req), 32'd1);
    tick();
    bus.ack = 1'b1;
    bus.rdata = 32'h11111111;
    present(OP_NONE, 32'h0000ABCD, 32'h0, 5'd2, 1'b1);
    chk("fl_req_ackcyc", 32'(bus.req), 32'd1);
    chk("fl_busy_ready", 32'(ex_ready), 32'd0);
    tick();
    bus.ack = 1'b0;
    chk("fl_wb_suppressed", 32'(wb_valid), 32'd0);
    chk("fl_req_drop", 32'(bus.req), 32'd0);
    chk("fl_ready_after", 32'(ex_ready), 32'd1);
    tick();
    idle_in();
    chk("fl_next_wb_valid", 32'(wb_valid), 32'd1);
    chk("fl_next_wb_data", wb_data, 32'h0000ABCD);

    // Flush in IDLE drops the presented op
    flush = 1'b1;
    present(OP_NONE, 32'h00005555, 32'h0, 5'd1, 1'b1);
    chk("fl_idle_ready", 32'(ex_ready), 32'd0);
    tick();
    chk("fl_idle_wb", 32'(wb_valid), 32'd0);
    present(OP_LW, 32'h00005000, 32'h0, 5'd1, 1'b1);
    tick();
    chk("fl_idle_req", 32'(bus.req), 32'd0);
    flush = 1'b0;
    idle_in();
    tick();
    chk("fl_idle_req2", 32'(bus.req), 32'd0);

    // Watchdog timeout on the short-timeout instance
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    present(OP_LW, 32'h00005004, 32'h0, 5'd4, 1'b1);
    tick();
    idle_in();
    chk("wd_req1", 32'(bus_wd.req), 32'd1);
    tick();
    tick();
    tick();
    chk("wd_req4", 32'(bus_wd.req), 32'd1);
    chk("wd_no_err_yet", 32'(wd_bus_err), 32'd0);
    tick();
    chk("wd_bus_err", 32'(wd_bus_err), 32'd1);
    chk("wd_req_drop", 32'(bus_wd.req), 32'd0);
    chk("wd_fault_addr", wd_fault_addr, 32'h00005004);
    chk("wd_idle_ready", 32'(wd_ex_ready), 32'd1);
    chk("wd_no_wb", 32'(wd_wb_valid), 32'd0);
    tick();
    chk("wd_err_pulse_end", 32'(wd_bus_err), 32'd0);
    chk("main_still_busy", 32'(bus.req), 32'd1);

    // Reset mid-BUSY on the main instance
    rstn = 1'b0;
    #1;
    chk("rstbusy_req", 32'(bus.req), 32'd0);
    chk("rstbusy_ready", 32'(ex_ready), 32'd0);
    rstn = 1'b1;
    bus.ack = 1'b1;
    bus.rdata = 32'h22222222;
    tick();
    bus.ack = 1'b0;
    chk("rstbusy_no_wb", 32'(wb_valid), 32'd0);
    chk("rstbusy_req_after", 32'(bus.req), 32'd0);
    tick();
    chk("rstbusy_no_wb2", 32'(wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage RISC-V pipeline, directly downstream of the EX-stage ALU.
- Consumes the ALU result (effective address, or plain result for non-memory ops) plus the store operand.
- Runs a request/acknowledge transaction on the data-memory port, with byte-lane alignment and load sign/zero extension.
- Emits a one-cycle writeback record; stalls EX while a memory access is outstanding.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles dmem_req may stay high without dmem_ack before abort; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rstn  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  LSU accepts this cycle; transfer occurs when ex_valid && ex_ready
- ex_alu_c  in  32  ALU result: address for memory ops, result otherwise
- ex_store_data  in  32  rs2 value for stores
- ex_mem_op  in  4  0000 NONE, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; any other code is treated as NONE
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- flush  in  1  kill the current or incoming instruction
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_be  out  4  byte-lane enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  transaction complete; rdata valid in the same cycle
- dmem_rdata  in  32  read data
- wb_valid  out  1  writeback record valid (single-cycle pulse)
- wb_rd  out  5  destination register
- wb_data  out  32  result
- wb_reg_write  out  1  write enable for the register file
- misalign  out  1  single-cycle pulse on a misaligned access
- bus_err  out  1  single-cycle pulse on a watchdog timeout
- fault_addr  out  32  offending byte address for misalign or bus_err

Behaviour:
- Reset, asynchronous on rstn low:
  - state goes to IDLE immediately.
  - All registered outputs go to 0: dmem_*, wb_*, misalign, bus_err, fault_addr.
  - Watchdog counter goes to 0.
  - ex_ready = 0 while rstn is low.
  - Reset during BUSY drops dmem_req immediately and never produces a writeback.
- States: IDLE, BUSY. ex_ready = (state == IDLE) && !flush.
- Accept with NONE op, or any illegal op code:
  - Next cycle: wb_valid = 1, wb_data = ex_alu_c, wb_rd = ex_rd.
  - wb_reg_write = ex_reg_write && (ex_rd != 0).
  - State stays IDLE, so back-to-back throughput is 1 per cycle.
- Misalignment check at accept:
  - LH, LHU, SH with addr[0] = 1 are misaligned.
  - LW, SW with addr[1:0] != 0 are misaligned.
  - Response, next cycle: misalign = 1, fault_addr = addr, wb_valid = 0, no bus request; state stays IDLE.
- Aligned memory op at accept:
  - Next cycle: dmem_req = 1 and state = BUSY.
  - dmem_addr, dmem_we, dmem_be and dmem_wdata are registered and held stable until the ack cycle.
- Byte enables and store data:
  - Byte ops: be = 0001 << addr[1:0].
  - Half ops: be = addr[1] ? 1100 : 0011.
  - Word ops: be = 1111.
  - SB replicates the byte to all 4 lanes; SH replicates the halfword to both halves.
  - Loads drive dmem_we = 0 with the same be rule.
- BUSY completion:
  - dmem_ack is honoured in any BUSY cycle, including the first.
  - In the ack cycle dmem_req is still 1.
  - Next cycle: dmem_req = 0, state = IDLE, and wb_valid = 1.
  - ex_ready is therefore high in the same cycle as wb_valid.
- Load result:
  - Select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - wb_reg_write = ex_reg_write && (rd != 0).
- Store result: wb_valid = 1 with wb_reg_write = 0 and wb_data = 0.
- Flush:
  - In IDLE, flush blocks acceptance; an op presented with flush = 1 is dropped.
  - In BUSY, the bus transaction runs to ack (it cannot be aborted), but its wb_valid is suppressed. A sticky "killed" bit records the flush.
- Watchdog:
  - The counter increments each BUSY cycle without ack.
  - When TIMEOUT_CYC != 0 and the count reaches TIMEOUT_CYC with no ack, the next cycle gives: dmem_req = 0, bus_err = 1, fault_addr = byte address, state = IDLE, no wb_valid.
  - The counter clears on entering BUSY.
- dmem_ack while IDLE is ignored.

Decomposition:
- Package lsu_pkg holds:
  - mem_op code localparams and the state encoding;
  - helpers is_load, is_store and is_misaligned.
- One combinational sub-module, lsu_align:
  - inputs: op, addr[1:0], store_data, rdata;
  - outputs: be, wdata, load_data.
- The FSM, holding registers and watchdog live in mem_stage_lsu.

Test Plan:
- NONE op, alu_c = 0x12345678, rd = 5, reg_write = 1 -> next cycle wb_valid = 1, wb_data = 0x12345678, wb_reg_write = 1, dmem_req never asserted; 4 back-to-back ops give 4 consecutive wb_valid pulses.
- LB at 0x00001003, ack 2 cycles after req, rdata = 0x80FF0000 -> dmem_addr = 0x00001000, be = 1000, wb_data = 0xFFFFFF80; repeat as LBU -> wb_data = 0x00000080; ex_ready low during BUSY.
- SH at 0x00002002, store_data = 0xABCD1234, ack in the first req cycle -> dmem_we = 1, be = 1100, wdata = 0x12341234, then wb_valid = 1 with wb_reg_write = 0.
- LW at 0x00003001 -> misalign pulse, fault_addr = 0x00003001, no dmem_req, no wb_valid; LW with rd = 0 at 0x3000 -> wb_valid = 1 with wb_reg_write = 0.
- LW accepted, flush pulsed during BUSY, ack 3 cycles later -> req held until ack, no wb_valid, next op accepted the cycle after ack; flush held with ex_valid in IDLE -> op dropped.
- TIMEOUT_CYC = 4, no ack -> bus_err one cycle after 4 un-acked req cycles, req drops, state IDLE; separately, rstn low mid-BUSY -> dmem_req = 0 immediately, no wb_valid after release.
